// File: rtl/muldiv_unit_pkg.sv
// ============================================================================
// Module   : muldiv_unit_pkg
// Purpose  : Shared operation codes, FSM state encodings and helpers for the
//            iterative multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package muldiv_unit_pkg;

  // Operation codes presented on i_op
  localparam logic [2:0] MUXOP_MULT  = 3'd0;
  localparam logic [2:0] MUXOP_MULTU = 3'd1;
  localparam logic [2:0] MUXOP_DIV   = 3'd2;
  localparam logic [2:0] MUXOP_DIVU  = 3'd3;
  localparam logic [2:0] MUXOP_MTHI  = 3'd4;
  localparam logic [2:0] MUXOP_MTLO  = 3'd5;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_FIX  = 2'd3;

  // Signed operations work on magnitudes and fix the signs at the end
  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == MUXOP_MULT) || (op == MUXOP_DIV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_unit.sv
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative HI/LO multiply/divide unit. One shift-add (multiply)
//            or restoring (divide) step per cycle on magnitudes, followed by a
//            single sign-fix cycle that writes HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cancel,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int               CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]         r_state;
  logic [1:0]         w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  // MUL: {partial product, multiplier}; DIV: {remainder, quotient}
  logic [2*WIDTH-1:0] r_acc;
  // Multiplicand (MUL) or divisor (DIV) magnitude
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_is_div;
  logic               r_done;

  logic               w_accept;
  logic               w_last;
  logic               w_fix_write;
  logic               w_div_step_en;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_abs;
  logic [WIDTH-1:0]   w_b_abs;
  logic [WIDTH:0]     w_add_a;
  logic [WIDTH:0]     w_add_b;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [2*WIDTH-1:0] w_div_step;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_accept = i_start & ~i_cancel & (r_state == ST_IDLE);
  assign w_last   = (r_cnt == CNT_ONE);

  // Operand magnitudes and signs captured at accept time
  assign w_a_neg = is_signed_op(i_op) & i_a[WIDTH-1];
  assign w_b_neg = is_signed_op(i_op) & i_b[WIDTH-1];
  assign w_a_abs = w_a_neg ? -i_a : i_a;
  assign w_b_abs = w_b_neg ? -i_b : i_b;

  // Single WIDTH+1 bit adder: add for MUL, subtract (a + ~b + 1) for DIV
  assign w_div_step_en = (r_state == ST_DIV);
  assign w_add_a = w_div_step_en ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
  assign w_add_b = w_div_step_en ? ~{1'b0, r_b} : {1'b0, r_b};
  assign w_sum   = w_add_a + w_add_b + {{WIDTH{1'b0}}, w_div_step_en};

  // Shift-add step: carry-out of the add becomes the new accumulator MSB
  assign w_mul_step = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring step: keep the difference only when it is non-negative
  assign w_div_step = w_sum[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                   : {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  // Sign fix-up; a zero divisor leaves remainder=|a| so HI restores to a
  assign w_prod   = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quot   = r_acc[WIDTH-1:0];
  assign w_rem    = r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi = r_is_div ? (r_sign_a ? -w_rem : w_rem) : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = !r_is_div        ? w_prod[WIDTH-1:0] :
                    (r_b == '0)      ? {WIDTH{1'b1}}     :
                    (r_sign_a ^ r_sign_b) ? -w_quot : w_quot;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next_state;
  end

  // Next-state logic; cancel overrides everything including a new start
  always_comb begin
    w_next_state = r_state;
    if (i_cancel) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            if (i_op == MUXOP_MULT || i_op == MUXOP_MULTU) w_next_state = ST_MUL;
            else if (i_op == MUXOP_DIV || i_op == MUXOP_DIVU) w_next_state = ST_DIV;
          end
        end
        ST_MUL:  if (w_last) w_next_state = ST_FIX;
        ST_DIV:  if (w_last) w_next_state = ST_FIX;
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State-decoded outputs
  always_comb begin
    o_busy      = (r_state != ST_IDLE);
    w_fix_write = (r_state == ST_FIX) & ~i_cancel;
  end

  // Datapath, counter and HI/LO registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_is_div <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_fix_write;
      if (i_cancel) begin
        r_cnt <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_accept) begin
              case (i_op)
                MUXOP_MTHI: r_hi <= i_a;
                MUXOP_MTLO: r_lo <= i_a;
                MUXOP_MULT, MUXOP_MULTU: begin
                  r_acc    <= {{WIDTH{1'b0}}, w_b_abs};
                  r_b      <= w_a_abs;
                  r_sign_a <= w_a_neg;
                  r_sign_b <= w_b_neg;
                  r_is_div <= 1'b0;
                  r_cnt    <= CNT_LOAD;
                end
                MUXOP_DIV, MUXOP_DIVU: begin
                  r_acc    <= {{WIDTH{1'b0}}, w_a_abs};
                  r_b      <= w_b_abs;
                  r_sign_a <= w_a_neg;
                  r_sign_b <= w_b_neg;
                  r_is_div <= 1'b1;
                  r_cnt    <= CNT_LOAD;
                end
                default: ;
              endcase
            end
          end
          ST_MUL: begin
            r_acc <= w_mul_step;
            r_cnt <= r_cnt - CNT_ONE;
          end
          ST_DIV: begin
            r_acc <= w_div_step;
            r_cnt <= r_cnt - CNT_ONE;
          end
          default: begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        endcase
      end
    end
  end

  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

`default_nettype wire
